data_store: RTL and testbench

//  Snapshot buffer for a channelised 64-bit sample stream tagged with a 7-bit channel index.

---
 rtl/data_store.sv | 69 ++++++
 tb/tb_data_store.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/data_store.sv
// Snapshot buffer: arms on reset, starts on the first index==0 beat and captures
// 2^ADDR_WIDTH consecutive valid words. It then freezes until reset, with read-first readback.
module data_store #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned INDEX_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic                   valid,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   assert_full,
  output logic                   assert_msb,
  output logic [INDEX_WIDTH-1:0] assert_index
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         wr_cnt_next_c;
  logic                  started;
  logic                  wr_en_c;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The counter MSB alone marks full: the count saturates at exactly DEPTH
  always_comb begin
    wr_en_c       = valid && (started || (index == '0)) && !wr_cnt[ADDR_WIDTH];
    wr_cnt_next_c = wr_cnt;
    if (wr_en_c) begin
      wr_cnt_next_c = wr_cnt + CW'(1);
    end
  end

  // Control state and registered status/read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt       <= '0;
      started      <= 1'b0;
      data_out     <= '0;
      assert_full  <= 1'b0;
      assert_msb   <= 1'b0;
      assert_index <= '0;
    end else begin
      wr_cnt      <= wr_cnt_next_c;
      assert_full <= wr_cnt_next_c[ADDR_WIDTH];
      assert_msb  <= wr_cnt_next_c[ADDR_WIDTH] | wr_cnt_next_c[ADDR_WIDTH-1];
      if (wr_en_c) begin
        started      <= 1'b1;
        assert_index <= index;
      end
      if (rd_en) begin
        data_out <= mem[rd_addr];
      end
    end
  end

  // Sample RAM: no reset, so contents survive a re-arm
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_cnt[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_data_store.sv
// Bench for data_store: reference model of capture and RAM, with a read-data scoreboard.
module tb_data_store;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic [6:0]  index;
  logic        valid;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [63:0] data_out;
  logic        assert_full;
  logic        assert_msb;
  logic [6:0]  assert_index;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [63:0] mem_m [int];
  int          m_cnt;
  bit          m_started;
  logic [6:0]  m_idx;
  logic [63:0] exp_q [$];
  logic [63:0] last_rd;

  data_store dut (
    .clk(clk), .rst(rst), .data_in(data_in), .index(index), .valid(valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .data_out(data_out),
    .assert_full(assert_full), .assert_msb(assert_msb), .assert_index(assert_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Read monitor: pops the expected word one cycle after each read strobe
  always @(posedge clk) begin
    if (rst && rd_en) begin
      #1;
      if (exp_q.size() == 0) begin
        check("rd_unexpected", data_out, 64'hx);
      end else begin
        last_rd = exp_q.pop_front();
        check("rd_data", data_out, last_rd);
      end
    end
  end

  task automatic model_reset();
    m_cnt     = 0;
    m_started = 1'b0;
    m_idx     = '0;
    last_rd   = '0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_full"},  64'(assert_full),  64'(m_cnt == 4096));
    check({tag, "_msb"},   64'(assert_msb),   64'(m_cnt >= 2048));
    check({tag, "_index"}, 64'(assert_index), 64'(m_idx));
  endtask

  // One clock of stimulus; the model sees the read before the write (read-first)
  task automatic cyc(input bit v, input logic [63:0] d, input logic [6:0] idx,
                     input bit re, input logic [11:0] ra);
    valid   = v;
    data_in = d;
    index   = idx;
    rd_en   = re;
    rd_addr = ra;
    if (re) exp_q.push_back(mem_m.exists(int'(ra)) ? mem_m[int'(ra)] : 64'hx);
    if (v && (m_started || idx == 7'd0) && m_cnt < 4096) begin
      mem_m[m_cnt] = d;
      m_cnt++;
      m_started = 1'b1;
      m_idx     = idx;
    end
    tick();
    valid = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"},  data_out,             64'h0);
    check({tag, "_full"},  64'(assert_full),     64'h0);
    check({tag, "_msb"},   64'(assert_msb),      64'h0);
    check({tag, "_index"}, 64'(assert_index),    64'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    model_reset();
    check_zero("reset");
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; valid = 1'b0; rd_en = 1'b0; data_in = '0; index = '0; rd_addr = '0;
    model_reset();

    // Reset held, then released with no traffic
    repeat (10) tick();
    check_zero("rst_hold");
    rst = 1'b1;
    repeat (3) tick();
    check_zero("rst_idle");

    // Full capture with overrun past 4096 beats
    for (int n = 0; n < 8196; n++) begin
      cyc(1'b1, 64'(n), 7'(n % 128), 1'b0, '0);
      check_flags("cap");
    end
    check("cap_last_index", 64'(assert_index), 64'd127);
    check("cap_full_end",   64'(assert_full),  64'd1);

    // Readback with 12-bit address wrap
    for (int k = 0; k < 8196; k++) cyc(1'b0, '0, '0, 1'b1, 12'(k));
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, '0, '0, 1'b0, 12'(k * 77));
      check("hold_dout", data_out, last_rd);
    end
    cyc(1'b0, '0, '0, 1'b1, 12'd4095);
    check("rd_4095", data_out, 64'd4095);

    // Alignment: beats before the first index 0 are dropped
    do_reset();
    for (int i = 5; i < 128; i++) cyc(1'b1, 64'(1000 + i), 7'(i), 1'b0, '0);
    check_flags("align_pre");
    cyc(1'b1, 64'hABC, 7'd0, 1'b0, '0);
    cyc(1'b1, 64'hABD, 7'd1, 1'b0, '0);
    check_flags("align_post");
    cyc(1'b0, '0, '0, 1'b1, 12'd0);
    check("align_addr0", data_out, 64'hABC);
    cyc(1'b0, '0, '0, 1'b1, 12'd1);
    check("align_addr1", data_out, 64'hABD);

    // Mid-capture asynchronous reset, then re-arm
    do_reset();
    for (int n = 0; n < 1000; n++) cyc(1'b1, 64'h5000 + 64'(n), 7'(n % 128), 1'b0, '0);
    check_flags("mid_1000");
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_zero("mid_async");
    tick();
    rst = 1'b1;
    cyc(1'b1, 64'h6666, 7'd3, 1'b0, '0);
    check_flags("mid_ignored");
    cyc(1'b1, 64'h7777, 7'd0, 1'b0, '0);
    cyc(1'b1, 64'h7778, 7'd1, 1'b0, '0);
    check_flags("mid_restart");
    cyc(1'b0, '0, '0, 1'b1, 12'd0);
    check("mid_addr0", data_out, 64'h7777);
    cyc(1'b0, '0, '0, 1'b1, 12'd2);
    check("mid_addr2_old", data_out, 64'h5002);

    // Same-cycle read and write of address 2 returns old data, then new
    cyc(1'b1, 64'hC0FFEE, 7'd2, 1'b1, 12'd2);
    check("coll_old", data_out, 64'h5002);
    cyc(1'b0, '0, '0, 1'b1, 12'd2);
    check("coll_new", data_out, 64'hC0FFEE);

    repeat (3) tick();
    check("q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
